// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps every input vector through N_FUNC function pairs and
// records per-function mismatch, lowest failing vector and reference minterm count.
module truth_table_checker #(
  parameter int N_IN   = 4,
  parameter int N_FUNC = 3,
  parameter int SETTLE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  output logic [N_IN-1:0]            vec,
  input  logic [N_FUNC-1:0]          ref_in,
  input  logic [N_FUNC-1:0]          cand_in,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [N_FUNC-1:0]          mismatch,
  output logic [N_FUNC*N_IN-1:0]     first_fail,
  output logic [N_FUNC*(N_IN+1)-1:0] ones_count
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);
  state_t                       state_q, state_d;
  logic [N_IN-1:0]              vec_q, vec_d;
  logic [3:0]                   cnt_q, cnt_d;
  logic [N_FUNC-1:0]            mm_q, mm_d;
  logic [N_FUNC*N_IN-1:0]       ff_q, ff_d;
  logic [N_FUNC*(N_IN+1)-1:0]   oc_q, oc_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      mm_q    <= '0;
      ff_q    <= '0;
      oc_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      mm_q    <= mm_d;
      ff_q    <= ff_d;
      oc_q    <= oc_d;
    end
  end
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    mm_d    = mm_q;
    ff_d    = ff_q;
    oc_d    = oc_q;
    case (state_q)
      S_IDLE: if (start && !abort) begin
        state_d = S_SETTLE;
        vec_d   = '0;
        cnt_d   = CNT_INIT;
        mm_d    = '0;
        ff_d    = '0;
        oc_d    = '0;
      end
      S_SETTLE: begin
        if (abort) state_d = S_IDLE;
        else if (cnt_q == 4'd0) state_d = S_SAMPLE;
        else cnt_d = cnt_q - 4'd1;
      end
      S_SAMPLE: begin
        if (abort) state_d = S_IDLE;
        else begin
          for (int i = 0; i < N_FUNC; i++) begin
            if (ref_in[i] != cand_in[i] && !mm_q[i]) begin
              mm_d[i]               = 1'b1;
              ff_d[i*N_IN +: N_IN]  = vec_q;
            end
            if (ref_in[i]) oc_d[i*(N_IN+1) +: N_IN+1] = oc_q[i*(N_IN+1) +: N_IN+1] + (N_IN+1)'(1);
          end
          // all-ones terminates the sweep so vec never wraps
          state_d = &vec_q ? S_DONE : S_SETTLE;
          vec_d   = &vec_q ? vec_q : vec_q + N_IN'(1);
          cnt_d   = CNT_INIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign vec        = vec_q;
  assign busy       = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done       = (state_q == S_DONE);
  assign pass       = ~|mm_q;
  assign mismatch   = mm_q;
  assign first_fail = ff_q;
  assign ones_count = oc_q;
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: table-driven, random and corner-case checks of truth_table_checker
module tb_truth_table_checker;
  localparam int NI = 4, NF = 3, ST = 1, NV = 16;
  logic clk = 0, rst_n = 1, start = 0, abort = 0, start2 = 0;
  always #5 clk = ~clk;
  logic [NI-1:0] vec;
  logic [NF-1:0] ref_in, cand_in, mismatch;
  logic busy, done, pass;
  logic [NF*NI-1:0] first_fail;
  logic [NF*(NI+1)-1:0] ones_count;
  logic [NF-1:0][NV-1:0] rt = '0, ct = '0;
  always_comb for (int i = 0; i < NF; i++) begin
    ref_in[i]  = rt[i][vec];
    cand_in[i] = ct[i][vec];
  end
  truth_table_checker #(.N_IN(NI), .N_FUNC(NF), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec(vec),
    .ref_in(ref_in), .cand_in(cand_in), .busy(busy), .done(done), .pass(pass),
    .mismatch(mismatch), .first_fail(first_fail), .ones_count(ones_count));
  logic [1:0] vec2, ff2;
  logic ref2, cand2, busy2, done2, pass2, mm2, ph2 = 0;
  logic [2:0] oc2;
  logic [3:0] t2 = '0, inj2 = '0;
  always_comb begin
    ref2  = t2[vec2];
    cand2 = ph2 ? (t2[vec2] ^ inj2[vec2]) : ~t2[vec2];
  end
  truth_table_checker #(.N_IN(2), .N_FUNC(1), .SETTLE(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .vec(vec2),
    .ref_in(ref2), .cand_in(cand2), .busy(busy2), .done(done2), .pass(pass2),
    .mismatch(mm2), .first_fail(ff2), .ones_count(oc2));
  int n_cmp = 0, n_err = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // expected results straight from the definition: lowest differing vector, popcount of ref
  task automatic model(input logic [NF-1:0][NV-1:0] r, input logic [NF-1:0][NV-1:0] c, input int lim,
                       output logic [NF-1:0] mm, output logic [NF*NI-1:0] ff, output logic [NF*(NI+1)-1:0] oc);
    logic [NV:0] m;
    m = (17'd1 << (lim + 1)) - 17'd1;
    mm = '0; ff = '0; oc = '0;
    for (int i = 0; i < NF; i++) begin
      mm[i] = |((r[i] ^ c[i]) & m[NV-1:0]);
      for (int v = lim; v >= 0; v--) if (r[i][v] != c[i][v]) ff[i*NI +: NI] = NI'(v);
      oc[i*(NI+1) +: NI+1] = (NI+1)'($countones(r[i] & m[NV-1:0]));
    end
  endtask
  task automatic team(output logic [NF-1:0][NV-1:0] r, output logic [NF-1:0][NV-1:0] c);
    logic [3:0] x;
    for (int v = 0; v < NV; v++) begin
      x = 4'(v);
      r[0][v] = x[3] & x[2];
      c[0][v] = x[3] & x[2];
      r[1][v] = (x[3] | ~x[2] & x[1]) & x[1];
      c[1][v] = (x[3] & x[1]) | (~x[2] & x[1]);
      r[2][v] = (x[3] & x[2]) | (~x[3] & ~x[2] & (x[1] | ~x[0]));
      c[2][v] = (x == 4'd0) || (x == 4'd2) || (x == 4'd3) || (x >= 4'd12);
    end
  endtask
  task automatic sweep(input int poke, input string tag);
    int cyc;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    cyc = 0;
    chk({tag, "_busy"}, busy, 1);
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke);
    end
    start = 0;
    chk({tag, "_done_latency"}, cyc, NV * (ST + 1));
  endtask
  task automatic results(input string tag, input logic [NF-1:0] mm, input logic [NF*NI-1:0] ff,
                         input logic [NF*(NI+1)-1:0] oc);
    chk({tag, "_mismatch"}, mismatch, mm);
    chk({tag, "_first_fail"}, first_fail, ff);
    chk({tag, "_ones_count"}, ones_count, oc);
    chk({tag, "_pass"}, pass, ~|mm);
  endtask
  typedef struct packed {
    logic [NF-1:0][NV-1:0] r, c;
    logic [NF-1:0] mm;
    logic [NF*NI-1:0] ff;
    logic [NF*(NI+1)-1:0] oc;
  } case_t;
  case_t cases [2];
  logic [NF-1:0] emm;
  logic [NF*NI-1:0] eff;
  logic [NF*(NI+1)-1:0] eoc;
  int cyc;
  initial begin
    #2 rst_n = 0;
    #1;
    chk("rst_vec", vec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 1);
    chk("rst_results", {mismatch, first_fail, ones_count}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    team(cases[0].r, cases[0].c);
    cases[0].mm = 3'b000; cases[0].ff = '0; cases[0].oc = {5'd7, 5'd6, 5'd4};
    cases[1] = cases[0];
    cases[1].c[0][10] = ~cases[1].c[0][10];
    cases[1].c[0][12] = ~cases[1].c[0][12];
    cases[1].mm = 3'b001; cases[1].ff = {8'h00, 4'hA};
    for (int k = 0; k < 2; k++) begin
      rt = cases[k].r; ct = cases[k].c;
      sweep(0, $sformatf("tab%0d", k));
      chk($sformatf("tab%0d_vec_end", k), vec, 4'hF);
      chk($sformatf("tab%0d_busy_end", k), busy, 0);
      results($sformatf("tab%0d", k), cases[k].mm, cases[k].ff, cases[k].oc);
      @(negedge clk);
      chk($sformatf("tab%0d_done_pulse", k), done, 0);
      chk($sformatf("tab%0d_vec_hold", k), vec, 4'hF);
    end
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NF; i++) begin
        rt[i] = 16'($urandom);
        case ($urandom_range(0, 2))
          0: ct[i] = rt[i];
          1: ct[i] = rt[i] ^ (16'd1 << $urandom_range(0, 15));
          default: ct[i] = rt[i] ^ 16'($urandom & $urandom);
        endcase
      end
      model(rt, ct, NV - 1, emm, eff, eoc);
      sweep(k == 0 ? 5 : 0, $sformatf("rnd%0d", k));
      results($sformatf("rnd%0d", k), emm, eff, eoc);
      @(negedge clk);
      chk($sformatf("rnd%0d_no_restart", k), {busy, done}, 0);
    end
    team(rt, ct);
    ct[1][3] = ~ct[1][3];
    ct[1][5] = ~ct[1][5];
    ct[2][5] = ~ct[2][5];
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    for (cyc = 0; cyc < 11; cyc++) @(negedge clk);
    chk("abort_vec_at_sample", vec, 5);
    abort = 1;
    @(negedge clk) abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_vec_held", vec, 5);
    model(rt, ct, 4, emm, eff, eoc);
    results("abort_partial", emm, eff, eoc);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", {busy, done}, 0);
    end
    @(negedge clk) begin start = 1; abort = 1; end
    @(negedge clk) begin start = 0; abort = 0; end
    chk("start_abort_idle", busy, 0);
    @(negedge clk);
    chk("start_abort_still_idle", busy, 0);
    results("start_abort_kept", emm, eff, eoc);
    team(rt, ct);
    sweep(0, "after_abort");
    results("after_abort", 3'b000, '0, {5'd7, 5'd6, 5'd4});
    ct[2][0] = ~ct[2][0];
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (9) @(negedge clk);
    chk("pre_reset_mm", mismatch, 3'b100);
    rst_n = 0;
    #1;
    chk("midrst_outputs", {vec, busy, done, pass}, 4'b0001 << 0);
    chk("midrst_results", {mismatch, first_fail, ones_count}, 0);
    @(negedge clk) rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_idle", {busy, done}, 0);
    end
    for (int k = 0; k < 2; k++) begin
      t2 = 4'($urandom);
      inj2 = (k == 1) ? 4'b0100 : 4'b0000;
      @(negedge clk) begin start2 = 1; ph2 = 0; end
      @(negedge clk) start2 = 0;
      cyc = 0;
      ph2 = 0;
      while (!done2 && cyc < 100) begin
        @(negedge clk);
        cyc++;
        ph2 = (cyc % 4 == 3);
      end
      chk($sformatf("s3_done_latency%0d", k), cyc, 16);
      chk($sformatf("s3_mismatch%0d", k), mm2, k == 1);
      chk($sformatf("s3_first_fail%0d", k), ff2, k == 1 ? 2 : 0);
      chk($sformatf("s3_ones%0d", k), oc2, $countones(t2));
      chk($sformatf("s3_pass%0d", k), pass2, k != 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
